rggen_register_host: RTL and testbench
======================================

# rggen_register_host

Initiator end of the `rggen_register_if` protocol. It accepts one host request at a time on a valid/ready request channel and checks the address against the block's window. It then broadcasts the access to every register's `register_if`, waits for the selected register to complete, and returns status and read data on a valid/ready response channel. It sits between the bus-protocol front end (APB/AXI4-Lite/Avalon bridge logic) and the array of register instances.

## Interface
- `ADDRESS_WIDTH`, 8: host address width.
- `LOCAL_ADDRESS_WIDTH`, 8: width of `register_if.address`.
- `BUS_WIDTH`, 32: data width; a multiple of 8.
- `REGISTERS`, 1: number of `register_if` instances; ≥1.
- `BASE_ADDRESS`, '0: first byte address of the window.
- `BYTE_SIZE`, 256: window size in bytes.
- `DEFAULT_READ_DATA`, '0: read data returned on any error.

Ports:
- `i_clk`  in  1  clock.
- `i_rst_n`  in  1  reset; one clock; asynchronous, active-low.
- `i_req_valid`  in  1  request valid.
- `o_req_ready`  out  1  request ready.
- `i_req_access`  in  2  `rggen_access`; bit `RGGEN_ACCESS_DATA_BIT`=1 means write.
- `i_req_address`  in  ADDRESS_WIDTH  byte address.
- `i_req_write_data`  in  BUS_WIDTH  write data.
- `i_req_strobe`  in  BUS_WIDTH/8  byte enables.
- `o_rsp_valid`  out  1  response valid.
- `i_rsp_ready`  in  1  response ready.
- `o_rsp_status`  out  2  `rggen_status`.
- `o_rsp_read_data`  out  BUS_WIDTH  read data.
- `register_if[REGISTERS]`  host modport  —  drives `valid`, `access`, `address`, `write_data` and `strobe`; samples `active`, `ready`, `status` and `read_data`.

## Operation
- FSM states: IDLE, BUSY, RESPONSE.
- IDLE:
  - `o_req_ready`=1.
  - On `i_req_valid`, capture access, address, data and strobe.
  - In-window address (BASE_ADDRESS ≤ addr < BASE_ADDRESS+BYTE_SIZE): go to BUSY.
  - Out-of-window address: go to RESPONSE with `RGGEN_DECODE_ERROR` and DEFAULT_READ_DATA.
- BUSY:
  - `register_if.valid`=1 on all instances.
  - `register_if.address` = (addr − BASE_ADDRESS) truncated to LOCAL_ADDRESS_WIDTH.
  - Captured fields are held constant for the whole access.
  - Each cycle, with A = vector of `active`:
    - A==0: register `RGGEN_SLAVE_ERROR` and DEFAULT_READ_DATA; go to RESPONSE.
    - A one-hot and selected `ready`=1: register that instance's `status` and `read_data`; go to RESPONSE.
    - A one-hot and `ready`=0: stay in BUSY with no limit. Backdoor stalls are legal.
    - A not one-hot (≥2 bits set): `RGGEN_SLAVE_ERROR` and DEFAULT_READ_DATA; go to RESPONSE.
  - For writes, the captured read data is forced to '0.
- RESPONSE:
  - `o_rsp_valid`=1; status and read data are held stable.
  - On `i_rsp_ready`, go to IDLE.
- Outside BUSY, `register_if.valid`=0 and `strobe`='0. Address and write data hold their last captured values.

## Timing
- Reset values (applied asynchronously while `i_rst_n`=0):
  - State = IDLE.
  - `o_req_ready`=1, `o_rsp_valid`=0, `o_rsp_status`=`RGGEN_OKAY`, `o_rsp_read_data`='0.
  - All `register_if.valid`=0.
- Accept in cycle N. `register_if.valid`=1 from N+1. A zero-wait register completes in N+1, so `o_rsp_valid` rises at N+2.
- Out-of-window request: `o_rsp_valid` rises at N+1, and `register_if.valid` never asserts.
- Each stall cycle (ready=0) delays the response by one cycle.
- Response handshake in cycle M: IDLE at M+1, so the next request can be accepted at M+1. Peak throughput is one access per 3 cycles.
- `o_req_ready` is registered; it is not combinationally dependent on `i_req_valid`.
- Reset during BUSY drops `register_if.valid` immediately. No response is issued for that access.

## Structure
- `rggen_rtl_pkg` holds `rggen_access`, `rggen_status` and `RGGEN_ACCESS_DATA_BIT`.
- The state enum is local to the module.
- Sub-module `rggen_register_response_collector` (combinational):
  - One-hot select of `status`/`read_data` by `active`.
  - Produces `any_active`, `multi_active` and `selected_ready`.
- SVA under `RGGEN_ENABLE_SVA`:
  - Captured fields are stable while in BUSY.
  - `o_rsp_*` are stable while valid and not ready.

## Test plan
- Read 0x04 with BASE_ADDRESS=0, REGISTERS=4, register 1 active and zero-wait returning 0xDEADBEEF -> `o_rsp_valid` at N+2 with `RGGEN_OKAY` and 0xDEADBEEF; `register_if.valid` high for exactly 1 cycle.
- Write 0x08, data 0x12345678, strobe 4'b0101, register 2 stalls 3 cycles -> `register_if` fields held 4 cycles; response at N+5 with OKAY and read data 0.
- Read 0x100 (out of window) -> DECODE_ERROR at N+1 with DEFAULT_READ_DATA; `register_if.valid` never asserts.
- Read 0x3C with no register active -> SLAVE_ERROR at N+2.
- Two registers active simultaneously -> SLAVE_ERROR; `i_rsp_ready` held low 5 cycles -> response held stable; next request accepted the cycle after the handshake.
- `i_rst_n` pulled low during a BUSY stall -> `register_if.valid` and `o_rsp_valid` drop at once; after release, `o_req_ready`=1 and a fresh read completes normally.

Source files
------------

// File: rtl/rggen_rtl_pkg.sv
// Shared access/status encodings for the rggen register protocol.
// Bit RGGEN_ACCESS_DATA_BIT of an access code marks a write.
package rggen_rtl_pkg;

  localparam int RGGEN_ACCESS_DATA_BIT = 1;

  typedef enum logic [1:0] {
    RGGEN_READ         = 2'b00,
    RGGEN_WRITE        = 2'b10,
    RGGEN_POSTED_WRITE = 2'b11
  } rggen_access;

  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'b00,
    RGGEN_EXOKAY       = 2'b01,
    RGGEN_SLAVE_ERROR  = 2'b10,
    RGGEN_DECODE_ERROR = 2'b11
  } rggen_status;

endpackage

// File: rtl/rggen_register_if.sv
// Host-to-register access bundle: the host drives the request, each register
// answers with active/ready/status/read_data.
interface rggen_register_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32
);
  logic                            valid;
  rggen_rtl_pkg::rggen_access      access;
  logic [ADDRESS_WIDTH-1:0]        address;
  logic [BUS_WIDTH-1:0]            write_data;
  logic [BUS_WIDTH/8-1:0]          strobe;
  logic                            active;
  logic                            ready;
  rggen_rtl_pkg::rggen_status      status;
  logic [BUS_WIDTH-1:0]            read_data;

  modport host (
    output valid, access, address, write_data, strobe,
    input  active, ready, status, read_data
  );

  modport register (
    input  valid, access, address, write_data, strobe,
    output active, ready, status, read_data
  );
endinterface

// File: rtl/rggen_register_response_collector.sv
// Purpose: one-hot select of the active register's response; flags none/many active.
// Latency: combinational. Backpressure: none, pure decode of the register side.
module rggen_register_response_collector
  import rggen_rtl_pkg::*;
#(
  parameter int REGISTERS = 1,
  parameter int BUS_WIDTH = 32
)(
  input  logic [REGISTERS-1:0]                active,
  input  logic [REGISTERS-1:0]                ready,
  input  logic [REGISTERS-1:0][1:0]           status,
  input  logic [REGISTERS-1:0][BUS_WIDTH-1:0] read_data,
  output logic                                any_active,
  output logic                                multi_active,
  output logic                                selected_ready,
  output rggen_status                         selected_status,
  output logic [BUS_WIDTH-1:0]                selected_read_data
);
  logic [1:0] status_or;

  assign any_active   = |active;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_active = (active & (active - REGISTERS'(1))) != '0;

  always_comb begin
    status_or          = '0;
    selected_read_data = '0;
    selected_ready     = 1'b0;
    for (int i = 0; i < REGISTERS; i++) begin
      if (active[i]) begin
        status_or          = status_or | status[i];
        selected_read_data = selected_read_data | read_data[i];
        selected_ready     = selected_ready | ready[i];
      end
    end
  end

  assign selected_status = rggen_status'(status_or);
endmodule

// File: rtl/rggen_register_host.sv
// Purpose: single-outstanding initiator for rggen_register_if; window decode + response return.
// Latency: accept N, register valid N+1, response N+2 (+1 per stall); decode error at N+1.
// Backpressure: req_ready only in IDLE; response held until rsp_ready.
module rggen_register_host
  import rggen_rtl_pkg::*;
#(
  parameter int                     ADDRESS_WIDTH       = 8,
  parameter int                     LOCAL_ADDRESS_WIDTH = 8,
  parameter int                     BUS_WIDTH           = 32,
  parameter int                     REGISTERS           = 1,
  parameter bit [ADDRESS_WIDTH-1:0] BASE_ADDRESS        = '0,
  parameter int                     BYTE_SIZE           = 256,
  parameter bit [BUS_WIDTH-1:0]     DEFAULT_READ_DATA   = '0
)(
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  rggen_access              i_req_access,
  input  logic [ADDRESS_WIDTH-1:0] i_req_address,
  input  logic [BUS_WIDTH-1:0]     i_req_write_data,
  input  logic [BUS_WIDTH/8-1:0]   i_req_strobe,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output rggen_status              o_rsp_status,
  output logic [BUS_WIDTH-1:0]     o_rsp_read_data,
  rggen_register_if.host           register_if[REGISTERS]
);
  typedef enum logic [1:0] {IDLE, BUSY, RESPONSE} state_e;

  // One extra bit so a window ending exactly at the top of the address space fits.
  localparam logic [ADDRESS_WIDTH:0] WINDOW_BASE = {1'b0, BASE_ADDRESS};
  localparam logic [ADDRESS_WIDTH:0] WINDOW_END  = WINDOW_BASE + BYTE_SIZE[ADDRESS_WIDTH:0];

  state_e                   state, state_next;
  rggen_access              access_q;
  logic [ADDRESS_WIDTH-1:0] address_q;
  logic [BUS_WIDTH-1:0]     write_data_q;
  logic [BUS_WIDTH/8-1:0]   strobe_q;
  rggen_status              status_q, status_next;
  logic [BUS_WIDTH-1:0]     read_data_q, read_data_next;

  logic                     busy, accept, in_window;
  logic [ADDRESS_WIDTH-1:0] offset;

  logic [REGISTERS-1:0]                active, ready;
  logic [REGISTERS-1:0][1:0]           status;
  logic [REGISTERS-1:0][BUS_WIDTH-1:0] read_data;
  logic                                any_active, multi_active, selected_ready;
  rggen_status                         selected_status;
  logic [BUS_WIDTH-1:0]                selected_read_data;

  assign busy        = state == BUSY;
  assign o_req_ready = state == IDLE;
  assign o_rsp_valid = state == RESPONSE;
  assign accept      = o_req_ready && i_req_valid;
  assign in_window   = ({1'b0, i_req_address} >= WINDOW_BASE) &&
                       ({1'b0, i_req_address} <  WINDOW_END);
  assign offset      = address_q - BASE_ADDRESS;

  for (genvar g = 0; g < REGISTERS; g++) begin : g_register
    assign register_if[g].valid      = busy;
    assign register_if[g].access     = access_q;
    assign register_if[g].address    = offset[LOCAL_ADDRESS_WIDTH-1:0];
    assign register_if[g].write_data = write_data_q;
    assign register_if[g].strobe     = busy ? strobe_q : '0;
    assign active[g]                 = register_if[g].active;
    assign ready[g]                  = register_if[g].ready;
    assign status[g]                 = register_if[g].status;
    assign read_data[g]              = register_if[g].read_data;
  end

  rggen_register_response_collector #(
    .REGISTERS (REGISTERS),
    .BUS_WIDTH (BUS_WIDTH)
  ) u_collector (
    .active             (active),
    .ready              (ready),
    .status             (status),
    .read_data          (read_data),
    .any_active         (any_active),
    .multi_active       (multi_active),
    .selected_ready     (selected_ready),
    .selected_status    (selected_status),
    .selected_read_data (selected_read_data)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      access_q     <= RGGEN_READ;
      address_q    <= '0;
      write_data_q <= '0;
      strobe_q     <= '0;
    end else if (accept) begin
      access_q     <= i_req_access;
      address_q    <= i_req_address;
      write_data_q <= i_req_write_data;
      strobe_q     <= i_req_strobe;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      status_q    <= RGGEN_OKAY;
      read_data_q <= '0;
    end else begin
      state       <= state_next;
      status_q    <= status_next;
      read_data_q <= read_data_next;
    end
  end

  always_comb begin
    state_next     = state;
    status_next    = status_q;
    read_data_next = read_data_q;
    case (state)
      IDLE: begin
        if (accept && in_window) begin
          state_next = BUSY;
        end else if (accept) begin
          state_next     = RESPONSE;
          status_next    = RGGEN_DECODE_ERROR;
          read_data_next = DEFAULT_READ_DATA;
        end
      end
      BUSY: begin
        if (!any_active || multi_active) begin
          state_next     = RESPONSE;
          status_next    = RGGEN_SLAVE_ERROR;
          read_data_next = DEFAULT_READ_DATA;
        end else if (selected_ready) begin
          state_next     = RESPONSE;
          status_next    = selected_status;
          read_data_next = access_q[RGGEN_ACCESS_DATA_BIT] ? '0 : selected_read_data;
        end
      end
      RESPONSE: begin
        if (i_rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign o_rsp_status    = status_q;
  assign o_rsp_read_data = read_data_q;

`ifdef RGGEN_ENABLE_SVA
  ast_busy_fields_stable: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    busy |=> !busy || $stable({access_q, address_q, write_data_q, strobe_q}));
  ast_rsp_stable: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (o_rsp_valid && !i_rsp_ready) |=> o_rsp_valid && $stable({o_rsp_status, o_rsp_read_data}));
`endif
endmodule

// File: tb/tb_rggen_register_host.sv
// Vector table for the named scenarios, randomized accesses against a window/response model,
// and a reset-during-stall sequence.
module tb_rggen_register_host;
  import rggen_rtl_pkg::*;

  localparam int           AW   = 16;
  localparam int           LAW  = 8;
  localparam int           BW   = 32;
  localparam int           R    = 4;
  localparam logic [15:0]  BASE = 16'h0000;
  localparam int           BS   = 256;
  localparam logic [31:0]  DEF  = 32'hBAD0_BAD0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  rggen_access req_access;
  logic [AW-1:0] req_address;
  logic [BW-1:0] req_wdata;
  logic [3:0]    req_strobe;
  logic          rsp_valid, rsp_ready;
  rggen_status   rsp_status;
  logic [BW-1:0] rsp_rdata;

  logic [R-1:0]  tb_active;
  rggen_status   tb_status [R];
  logic [BW-1:0] tb_rdata  [R];
  int            stall_target, stall_cnt;
  logic          tb_ready;
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  rggen_register_if #(.ADDRESS_WIDTH(LAW), .BUS_WIDTH(BW)) reg_if[R] ();

  for (genvar g = 0; g < R; g++) begin : g_reg
    assign reg_if[g].active    = tb_active[g];
    assign reg_if[g].ready     = tb_ready;
    assign reg_if[g].status    = tb_status[g];
    assign reg_if[g].read_data = tb_rdata[g];
  end

  // Register-side stall: ready rises after stall_target cycles of valid.
  assign tb_ready = stall_cnt >= stall_target;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           stall_cnt <= 0;
    else if (!reg_if[0].valid)            stall_cnt <= 0;
    else if (!tb_ready)                   stall_cnt <= stall_cnt + 1;
  end

  rggen_register_host #(
    .ADDRESS_WIDTH(AW), .LOCAL_ADDRESS_WIDTH(LAW), .BUS_WIDTH(BW), .REGISTERS(R),
    .BASE_ADDRESS(BASE), .BYTE_SIZE(BS), .DEFAULT_READ_DATA(DEF)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_access(req_access),
    .i_req_address(req_address), .i_req_write_data(req_wdata), .i_req_strobe(req_strobe),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_status(rsp_status),
    .o_rsp_read_data(rsp_rdata), .register_if(reg_if)
  );

  typedef struct {
    string       name;
    rggen_access acc;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [3:0]  active;
    int          stall;
    rggen_status sel_st;
    logic [31:0] sel_rd;
    int          hold;
    rggen_status exp_st;
    logic [31:0] exp_rd;
    int          exp_lat;
    int          exp_vcyc;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] valid_vec();
    return {reg_if[3].valid, reg_if[2].valid, reg_if[1].valid, reg_if[0].valid};
  endfunction

  // Expected response from the window rule and the number of active registers.
  task automatic model(input logic [15:0] addr, input logic [3:0] act, input int stall,
                       input bit wr, input rggen_status st, input logic [31:0] rd,
                       output rggen_status est, output logic [31:0] erd,
                       output int lat, output int vcyc);
    if (int'(addr) < int'(BASE) || int'(addr) >= int'(BASE) + BS) begin
      est = RGGEN_DECODE_ERROR; erd = DEF; lat = 1; vcyc = 0;
    end else if ($countones(act) != 1) begin
      est = RGGEN_SLAVE_ERROR; erd = DEF; lat = 2; vcyc = 1;
    end else begin
      est = st; erd = wr ? 32'h0 : rd; lat = 2 + stall; vcyc = 1 + stall;
    end
  endtask

  // Starts and ends on a falling edge; accept is the next rising edge.
  task automatic run_vec(input vec_t v);
    int          sel, lat, vcyc;
    bit          got, fields_ok, strobe_ok, stable;
    rggen_status st0;
    logic [31:0] rd0;
    logic [7:0]  exp_la;
    sel = -1;
    for (int i = R - 1; i >= 0; i--) if (v.active[i]) sel = i;
    for (int i = 0; i < R; i++) begin
      tb_rdata[i]  = (i == sel) ? v.sel_rd : ~v.sel_rd ^ 32'(i);
      tb_status[i] = (i == sel) ? v.sel_st : rggen_status'(~v.sel_st);
    end
    tb_active    = v.active;
    stall_target = v.stall;
    exp_la       = 8'(v.addr - BASE);
    check({v.name, ".req_ready"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_access = v.acc; req_address = v.addr;
    req_wdata = v.wdata; req_strobe = v.strb;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = ~req_wdata; req_address = ~req_address; req_strobe = ~req_strobe;
    lat = 0; vcyc = 0; got = 0; fields_ok = 1; strobe_ok = 1;
    for (int c = 1; c <= 64; c++) begin
      if (reg_if[0].valid) begin
        vcyc++;
        if (valid_vec() != 4'hF || reg_if[1].address != exp_la || reg_if[2].write_data != v.wdata ||
            reg_if[3].strobe != v.strb || reg_if[0].access != v.acc)
          fields_ok = 0;
      end else if (valid_vec() != 4'h0 || reg_if[0].strobe != 4'h0) begin
        strobe_ok = 0;
      end
      if (rsp_valid) begin
        lat = c; got = 1;
        break;
      end
      @(negedge clk);
    end
    check({v.name, ".rsp_seen"}, 64'(got), 64'd1);
    check({v.name, ".latency"}, 64'(lat), 64'(v.exp_lat));
    check({v.name, ".valid_cycles"}, 64'(vcyc), 64'(v.exp_vcyc));
    check({v.name, ".status"}, 64'(rsp_status), 64'(v.exp_st));
    check({v.name, ".read_data"}, 64'(rsp_rdata), 64'(v.exp_rd));
    check({v.name, ".reg_fields"}, 64'(fields_ok), 64'd1);
    check({v.name, ".idle_strobe"}, 64'(strobe_ok), 64'd1);
    st0 = rsp_status; rd0 = rsp_rdata; stable = 1;
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_status != st0 || rsp_rdata != rd0) stable = 0;
    end
    if (v.hold > 0) check({v.name, ".rsp_held"}, 64'(stable), 64'd1);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check({v.name, ".back_idle"}, {62'd0, req_ready, rsp_valid}, 64'b10);
  endtask

  vec_t vecs[8];

  initial begin
    vec_t rv;
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; req_access = RGGEN_READ;
    req_address = '0; req_wdata = '0; req_strobe = '0;
    tb_active = '0; stall_target = 0;
    for (int i = 0; i < R; i++) begin tb_status[i] = RGGEN_OKAY; tb_rdata[i] = '0; end

    //         name     acc          addr     wdata         strb     act      stl sel_st              sel_rd        hold exp_st              exp_rd        lat vcyc
    vecs[0] = '{"rd04",   RGGEN_READ,  16'h004, 32'h0,        4'b1111, 4'b0010, 0, RGGEN_OKAY,         32'hDEADBEEF, 0, RGGEN_OKAY,         32'hDEADBEEF, 2, 1};
    vecs[1] = '{"wr08",   RGGEN_WRITE, 16'h008, 32'h12345678, 4'b0101, 4'b0100, 3, RGGEN_OKAY,         32'hFFFF0000, 0, RGGEN_OKAY,         32'h0,        5, 4};
    vecs[2] = '{"rd100",  RGGEN_READ,  16'h100, 32'h0,        4'b1111, 4'b0001, 0, RGGEN_OKAY,         32'h11223344, 0, RGGEN_DECODE_ERROR, DEF,          1, 0};
    vecs[3] = '{"rd3c",   RGGEN_READ,  16'h03C, 32'h0,        4'b1111, 4'b0000, 0, RGGEN_OKAY,         32'h11223344, 0, RGGEN_SLAVE_ERROR,  DEF,          2, 1};
    vecs[4] = '{"multi",  RGGEN_READ,  16'h010, 32'h0,        4'b1111, 4'b0011, 0, RGGEN_OKAY,         32'h0000ABCD, 5, RGGEN_SLAVE_ERROR,  DEF,          2, 1};
    vecs[5] = '{"exokay", RGGEN_READ,  16'h020, 32'h0,        4'b1111, 4'b1000, 1, RGGEN_EXOKAY,       32'hCAFEF00D, 1, RGGEN_EXOKAY,       32'hCAFEF00D, 3, 2};
    vecs[6] = '{"top_ff", RGGEN_READ,  16'h0FF, 32'h0,        4'b0001, 4'b0001, 0, RGGEN_SLAVE_ERROR,  32'h11111111, 0, RGGEN_SLAVE_ERROR,  32'h11111111, 2, 1};
    vecs[7] = '{"wr00",   RGGEN_WRITE, 16'h000, 32'hA5A5A5A5, 4'b1111, 4'b0001, 0, RGGEN_OKAY,         32'h77777777, 0, RGGEN_OKAY,         32'h0,        2, 1};

    #12;
    check("reset.req_ready", 64'(req_ready), 64'd1);
    check("reset.rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset.rsp_status", 64'(rsp_status), 64'(RGGEN_OKAY));
    check("reset.rsp_data", 64'(rsp_rdata), 64'd0);
    check("reset.reg_valid", 64'(valid_vec()), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Reset while a register is stalling.
    tb_active = 4'b0001; stall_target = 1000;
    req_valid = 1'b1; req_access = RGGEN_READ; req_address = 16'h00C; req_strobe = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy.pre_valid", 64'(valid_vec()), 64'hF);
    rst_n = 1'b0;
    #1;
    check("rst_busy.reg_valid", 64'(valid_vec()), 64'd0);
    check("rst_busy.rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_busy.req_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy.no_rsp", 64'(rsp_valid), 64'd0);
    vecs[0].name = "post_rst";
    run_vec(vecs[0]);

    for (int n = 0; n < 40; n++) begin
      rv.name  = $sformatf("rand%0d", n);
      rv.acc   = ($urandom_range(0, 1) == 1) ? RGGEN_WRITE : RGGEN_READ;
      rv.addr  = 16'($urandom_range(0, 319));
      rv.wdata = $urandom;
      rv.strb  = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 9))
        0, 1:    rv.active = 4'b0000;
        2, 3:    rv.active = 4'($urandom_range(1, 15));
        default: rv.active = 4'b0001 << $urandom_range(0, 3);
      endcase
      rv.stall  = $urandom_range(0, 4);
      rv.sel_st = rggen_status'($urandom_range(0, 2));
      rv.sel_rd = $urandom;
      rv.hold   = $urandom_range(0, 2);
      model(rv.addr, rv.active, rv.stall, rv.acc == RGGEN_WRITE, rv.sel_st, rv.sel_rd,
            rv.exp_st, rv.exp_rd, rv.exp_lat, rv.exp_vcyc);
      run_vec(rv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
